// File: rtl/sprite_pixel_locator.sv
// sprite_pixel_locator: per-pixel object hit test against a double-buffered object table, with transparent colour merge
module sprite_pixel_locator #(
  parameter int          NUM_OBJ    = 4,
  parameter int          SPR_W      = 16,
  parameter int          SPR_AW     = 4,
  parameter logic [11:0] TRANSP_KEY = 12'hF0F
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [9:0]                 pixel_x,
  input  logic [9:0]                 pixel_y,
  input  logic                       video_on,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic                       frame_tick,
  input  logic                       obj_we,
  input  logic [$clog2(NUM_OBJ)-1:0] obj_sel,
  input  logic [9:0]                 obj_x,
  input  logic [9:0]                 obj_y,
  input  logic [2:0]                 obj_idx,
  input  logic [11:0]                bg_color,
  output logic [SPR_AW-1:0]          rom_row,
  output logic [SPR_AW-1:0]          rom_col,
  output logic [2:0]                 rom_index,
  input  logic [11:0]                rom_color,
  output logic [11:0]                rgb,
  output logic                       hsync_out,
  output logic                       vsync_out
);
  logic [9:0]        sh_x   [NUM_OBJ];
  logic [9:0]        sh_y   [NUM_OBJ];
  logic [2:0]        sh_idx [NUM_OBJ];
  logic [9:0]        act_x  [NUM_OBJ];
  logic [9:0]        act_y  [NUM_OBJ];
  logic [2:0]        act_idx[NUM_OBJ];
  logic              hit, hit_d1, hit_d2, von_d1, von_d2;
  logic [2:0]        hit_idx;
  logic [SPR_AW-1:0] hit_row, hit_col;
  logic [2:0]        hs, vs;
  // Commit reads the pre-write shadow, so a same-cycle write waits for the next tick
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        sh_x[i]    <= '0;
        sh_y[i]    <= '0;
        sh_idx[i]  <= '0;
        act_x[i]   <= '0;
        act_y[i]   <= '0;
        act_idx[i] <= '0;
      end
    end else begin
      if (frame_tick)
        for (int i = 0; i < NUM_OBJ; i++) begin
          act_x[i]   <= sh_x[i];
          act_y[i]   <= sh_y[i];
          act_idx[i] <= sh_idx[i];
        end
      if (obj_we) begin
        sh_x[obj_sel]   <= obj_x;
        sh_y[obj_sel]   <= obj_y;
        sh_idx[obj_sel] <= obj_idx;
      end
    end
  // Scan from the highest slot down so the lowest hitting slot wins; 11-bit bounds avoid wrap
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_row = '0;
    hit_col = '0;
    for (int k = NUM_OBJ - 1; k >= 0; k--)
      if (video_on && act_idx[k] != 3'd0 &&
          pixel_x >= act_x[k] && {1'b0, pixel_x} < {1'b0, act_x[k]} + 11'(SPR_W) &&
          pixel_y >= act_y[k] && {1'b0, pixel_y} < {1'b0, act_y[k]} + 11'(SPR_W)) begin
        hit     = 1'b1;
        hit_idx = act_idx[k];
        hit_row = SPR_AW'(pixel_y - act_y[k]);
        hit_col = SPR_AW'(pixel_x - act_x[k]);
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rom_row   <= '0;
      rom_col   <= '0;
      rom_index <= '0;
      hit_d1    <= 1'b0;
      hit_d2    <= 1'b0;
      von_d1    <= 1'b0;
      von_d2    <= 1'b0;
      rgb       <= '0;
      hs        <= '1;
      vs        <= '1;
    end else begin
      rom_row   <= hit_row;
      rom_col   <= hit_col;
      rom_index <= hit_idx;
      hit_d1    <= hit;
      von_d1    <= video_on;
      hit_d2    <= hit_d1;
      von_d2    <= von_d1;
      rgb       <= !von_d2 ? 12'h000 : (hit_d2 && rom_color != TRANSP_KEY) ? rom_color : bg_color;
      hs        <= {hs[1:0], hsync_in};
      vs        <= {vs[1:0], vsync_in};
    end
  assign hsync_out = hs[2];
  assign vsync_out = vs[2];
endmodule

// File: tb/tb_sprite_pixel_locator.sv
// tb_sprite_pixel_locator: directed vectors with hand-computed expectations and a 1-cycle ROM model
module tb_sprite_pixel_locator;
  logic        clk, rst_n;
  logic [9:0]  pixel_x, pixel_y, obj_x, obj_y;
  logic        video_on, hsync_in, vsync_in, frame_tick, obj_we;
  logic [1:0]  obj_sel;
  logic [2:0]  obj_idx, rom_index;
  logic [11:0] bg_color, rom_color, rgb;
  logic [3:0]  rom_row, rom_col;
  logic        hsync_out, vsync_out;
  logic [11:0] lut [8];
  int          n_cmp = 0;
  int          n_bad = 0;

  sprite_pixel_locator dut (
    .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_tick(frame_tick), .obj_we(obj_we),
    .obj_sel(obj_sel), .obj_x(obj_x), .obj_y(obj_y), .obj_idx(obj_idx), .bg_color(bg_color),
    .rom_row(rom_row), .rom_col(rom_col), .rom_index(rom_index), .rom_color(rom_color),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial rom_color = 12'h000;
  always @(posedge clk) rom_color <= lut[rom_index];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] s, input logic [9:0] x, input logic [9:0] y, input logic [2:0] i);
    obj_sel = s; obj_x = x; obj_y = y; obj_idx = i; obj_we = 1'b1;
    step();
    obj_we = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y);
    pixel_x = x; pixel_y = y;
  endtask

  initial begin
    rst_n = 1'b0; pixel_x = '0; pixel_y = '0; video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    frame_tick = 1'b0; obj_we = 1'b0; obj_sel = '0; obj_x = '0; obj_y = '0; obj_idx = '0;
    bg_color = 12'h123;
    for (int i = 0; i < 8; i++) lut[i] = 12'h000;
    lut[1] = 12'hF0F; lut[2] = 12'h0A0; lut[3] = 12'h00F;
    repeat (3) step();
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_idx", 32'(rom_index), 32'h0);
    chk("rst_hs", 32'(hsync_out), 32'h1);
    chk("rst_vs", 32'(vsync_out), 32'h1);
    rst_n = 1'b1;
    step();
    video_on = 1'b1;
    // single hit and 3-cycle colour latency
    wr(2'd0, 10'd100, 10'd50, 3'd2);
    tick();
    pix(10'd105, 10'd53);
    step();
    chk("hit_row", 32'(rom_row), 32'd3);
    chk("hit_col", 32'(rom_col), 32'd5);
    chk("hit_idx", 32'(rom_index), 32'd2);
    pix(10'd0, 10'd0);
    step(); step();
    chk("hit_rgb", 32'(rgb), 32'h0A0);
    step();
    chk("bg_rgb", 32'(rgb), 32'h123);
    // priority and transparency
    wr(2'd0, 10'd200, 10'd200, 3'd1);
    wr(2'd1, 10'd200, 10'd200, 3'd3);
    tick();
    pix(10'd205, 10'd205);
    step();
    chk("prio_idx", 32'(rom_index), 32'd1);
    pix(10'd0, 10'd0);
    step(); step();
    chk("transp_rgb", 32'(rgb), 32'h123);
    // shadow commit
    wr(2'd2, 10'd300, 10'd300, 3'd3);
    pix(10'd302, 10'd301);
    step();
    chk("shadow_hidden", 32'(rom_index), 32'd0);
    tick();
    step();
    chk("commit_idx", 32'(rom_index), 32'd3);
    chk("commit_row", 32'(rom_row), 32'd1);
    chk("commit_col", 32'(rom_col), 32'd2);
    obj_sel = 2'd2; obj_x = 10'd400; obj_y = 10'd300; obj_idx = 3'd3; obj_we = 1'b1; frame_tick = 1'b1;
    step();
    obj_we = 1'b0; frame_tick = 1'b0;
    pix(10'd402, 10'd301);
    step();
    chk("wt_new_hidden", 32'(rom_index), 32'd0);
    pix(10'd302, 10'd301);
    step();
    chk("wt_old_kept", 32'(rom_index), 32'd3);
    tick();
    pix(10'd402, 10'd301);
    step();
    chk("wt_new_vis", 32'(rom_index), 32'd3);
    pix(10'd416, 10'd301);
    step();
    chk("x_plus_w", 32'(rom_index), 32'd0);
    // right-edge clipping and video_on gating
    wr(2'd3, 10'd630, 10'd100, 3'd2);
    tick();
    pix(10'd639, 10'd100);
    step();
    chk("clip_col", 32'(rom_col), 32'd9);
    chk("clip_idx", 32'(rom_index), 32'd2);
    pix(10'd629, 10'd100);
    step();
    chk("left_miss", 32'(rom_index), 32'd0);
    pix(10'd646, 10'd100);
    step();
    chk("right_miss", 32'(rom_index), 32'd0);
    pix(10'd635, 10'd115);
    step();
    chk("bot_row", 32'(rom_row), 32'd15);
    chk("bot_idx", 32'(rom_index), 32'd2);
    pix(10'd635, 10'd116);
    step();
    chk("below_miss", 32'(rom_index), 32'd0);
    pix(10'd639, 10'd100);
    video_on = 1'b0;
    step();
    chk("voff_idx", 32'(rom_index), 32'd0);
    step(); step();
    chk("voff_rgb", 32'(rgb), 32'h0);
    video_on = 1'b1;
    // sync alignment
    hsync_in = 1'b0;
    step(); step();
    chk("hs_d2", 32'(hsync_out), 32'h1);
    step();
    chk("hs_d3", 32'(hsync_out), 32'h0);
    hsync_in = 1'b1; vsync_in = 1'b0;
    step(); step();
    chk("vs_d2", 32'(vsync_out), 32'h1);
    step();
    chk("vs_d3", 32'(vsync_out), 32'h0);
    // reset mid-stream
    hsync_in = 1'b0;
    repeat (3) step();
    chk("pre_rst_rgb", 32'(rgb), 32'h0A0);
    chk("pre_rst_hs", 32'(hsync_out), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rgb", 32'(rgb), 32'h0);
    chk("mid_rst_idx", 32'(rom_index), 32'd0);
    chk("mid_rst_hs", 32'(hsync_out), 32'h1);
    chk("mid_rst_vs", 32'(vsync_out), 32'h1);
    step();
    rst_n = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    step(); step();
    chk("post_rst_edge", 32'(rom_index), 32'd0);
    pix(10'd205, 10'd205);
    step();
    chk("post_rst_prio", 32'(rom_index), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
